multiplier_controller_taint_track_1bit: RTL and testbench
=========================================================

Name: multiplier_controller_taint_track_1bit

Overview:
- FSM controller that sequences the 1-bit taint-tracked sequential shift-add multiplier datapath.
- Issues per-cycle control strobes: mrld, mdld, rsclear, rsload, rsshr.
- Each strobe carries a 1-bit taint companion that tells the datapath whether the control decision depended on tainted data.
- Sits between the external requester (start/done) and the datapath. Consumes only the datapath's multiplierReg/multiplierReg_t.

Parameters:
WIDTH, 4, operand width; must match datapath WIDTH; legal range WIDTH >= 2

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
start_t  input  1  taint of start
multiplierReg  input  WIDTH  datapath multiplier register
multiplierReg_t  input  1  taint of multiplierReg
mrld  output  1  load multiplier register
mrld_t  output  1  taint of mrld
mdld  output  1  load multiplicand register
mdld_t  output  1  taint of mdld
rsclear  output  1  clear running sum
rsclear_t  output  1  taint of rsclear
rsload  output  1  add multiplicand into running sum
rsload_t  output  1  taint of rsload
rsshr  output  1  arithmetic shift running sum right by 1
rsshr_t  output  1  taint of rsshr
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse, product valid
done_t  output  1  taint of done

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE, count=0, ctrl_t=0.
  - All strobes, done and busy are 0; all _t outputs are 0.
- Internal state:
  - state: IDLE, LOAD, ADD, SHIFT, DONE.
  - count: $clog2(WIDTH) bits, index of the multiplier bit under test.
  - ctrl_t: sticky state-taint bit.
- IDLE: no strobes.
  - start=1 -> LOAD next cycle.
  - start is ignored in every other state.
- LOAD: mrld=mdld=rsclear=1 for exactly one cycle; count<=0; next ADD.
- ADD: rsload = multiplierReg[count] (Mealy output, same cycle); next SHIFT.
- SHIFT: rsshr=1.
  - count==WIDTH-1 -> DONE.
  - Otherwise count<=count+1, next ADD.
- DONE: done=1 for one cycle; next IDLE. A new start is accepted from the following IDLE cycle.
- Latency:
  - start sampled at edge N -> LOAD cycle N+1 -> ADD/SHIFT pairs over cycles N+2..N+1+2*WIDTH -> done at cycle N+2+2*WIDTH.
  - WIDTH=4: done is 10 cycles after the start edge.
- Strobe exclusivity: rsload and rsshr are never high together. rsclear is only ever high with mrld/mdld.
- Taint rules:
  - ctrl_t is set (sticky) when:
    - in IDLE with start_t=1, regardless of start, because the accept/stay decision is tainted; or
    - in ADD with multiplierReg_t=1, because the branch decision is tainted.
  - ctrl_t clears only on reset.
  - mrld_t, mdld_t, rsclear_t, rsshr_t, done_t = ctrl_t, registered value, valid every cycle including IDLE.
  - rsload_t = ctrl_t | (state==ADD & multiplierReg_t).
  - Every _t output stays at its taint value even when its strobe is 0, because absence of a strobe is also a decision.
- Boundaries:
  - Reset mid-operation: abandon the sequence next edge; no done pulse.
  - start held high continuously: one operation per start acceptance; re-accepted in the IDLE cycle after DONE.
  - multiplierReg = 0: no rsload pulses; rsshr pulses WIDTH times.

Optional Feature:
- Macro: MULT_CTRL_ABORT_EN.
- When defined:
  - Adds inputs abort (1) and abort_t (1).
  - abort=1 in LOAD/ADD/SHIFT -> IDLE next edge.
  - During the abort cycle itself, strobes are still driven per the current state. No done pulse is issued.
  - abort_t=1 sampled in any non-IDLE state sets ctrl_t.
  - abort in IDLE or DONE is ignored.
- When undefined: ports are absent; behaviour is exactly as above.

Test Plan:
- Reset, then idle 5 cycles with start=0, start_t=0 -> all outputs 0, busy=0, all _t=0.
- WIDTH=4, start pulse, multiplierReg=4'b1011, all taints 0 -> LOAD, then rsload pattern per ADD = 1,1,0,1, 4 rsshr pulses, done exactly 10 cycles after start, all _t=0.
- multiplierReg=0, start -> zero rsload pulses, 4 rsshr pulses, done at +10 cycles.
- Same as the 4'b1011 case but multiplierReg_t=1 -> rsload_t=1 in the first ADD cycle; all _t=1 from the next cycle on until reset; done_t=1.
- start_t=1 for one IDLE cycle with start=0 -> all _t=1 from the next cycle onward; subsequent operation still sequences correctly; reset clears all _t to 0.
- Assert reset during the third SHIFT -> next cycle IDLE, busy=0, no done; a new start gives a full 10-cycle sequence. With MULT_CTRL_ABORT_EN: abort in ADD -> IDLE next edge, no done; abort_t=1 -> all _t=1.

Source files
------------

// File: rtl/multiplier_controller_taint_track_1bit.sv
// -----------------------------------------------------------------------------
// multiplier_controller_taint_track_1bit
//
// FSM controller for the 1-bit taint-tracked sequential shift-add multiplier
// datapath. It sequences LOAD, then WIDTH ADD/SHIFT pairs, then DONE. Every
// control strobe has a 1-bit taint companion. The companion is set when the
// decision that produced the strobe depended on tainted data.
//
// Optional feature: define MULT_CTRL_ABORT_EN to add the abort/abort_t inputs.
//
// Ports:
//   clk, reset        clock (posedge) and synchronous active-high reset
//   start, start_t    multiply request (sampled only in IDLE) and its taint
//   multiplierReg     datapath multiplier register, WIDTH bits
//   multiplierReg_t   taint of multiplierReg
//   abort, abort_t    (MULT_CTRL_ABORT_EN only) abandon operation, and taint
//   mrld/mdld         load multiplier/multiplicand registers
//   rsclear           clear running sum
//   rsload            add multiplicand into running sum (Mealy, ADD state)
//   rsshr             arithmetic shift running sum right by 1
//   busy              high in every state except IDLE
//   done              one-cycle pulse, product valid
//   *_t               taint companion of each strobe
// -----------------------------------------------------------------------------
module multiplier_controller_taint_track_1bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic             multiplierReg_t,
`ifdef MULT_CTRL_ABORT_EN
    input  logic             abort,
    input  logic             abort_t,
`endif
    output logic             mrld,
    output logic             mrld_t,
    output logic             mdld,
    output logic             mdld_t,
    output logic             rsclear,
    output logic             rsclear_t,
    output logic             rsload,
    output logic             rsload_t,
    output logic             rsshr,
    output logic             rsshr_t,
    output logic             busy,
    output logic             done,
    output logic             done_t
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          ctrl_t;
    logic          abort_hit;
    logic          abort_taint;

`ifdef MULT_CTRL_ABORT_EN
    // Abort only acts in the working states; IDLE and DONE ignore it.
    assign abort_hit   = abort & ((state == LOAD) | (state == ADD) | (state == SHIFT));
    assign abort_taint = abort_t & (state != IDLE);
`else
    assign abort_hit   = 1'b0;
    assign abort_taint = 1'b0;
`endif

    // Strobes other than rsload are registered. They are computed for the
    // state being entered, so they line up with that state's cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            ctrl_t  <= 1'b0;
            mrld    <= 1'b0;
            mdld    <= 1'b0;
            rsclear <= 1'b0;
            rsshr   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            mrld    <= 1'b0;
            mdld    <= 1'b0;
            rsclear <= 1'b0;
            rsshr   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b1;
            case (state)
                IDLE: begin
                    // The accept/stay decision is tainted whatever start is.
                    if (start_t) ctrl_t <= 1'b1;
                    if (start) begin
                        state   <= LOAD;
                        mrld    <= 1'b1;
                        mdld    <= 1'b1;
                        rsclear <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    count <= '0;
                    state <= ADD;
                end
                ADD: begin
                    if (multiplierReg_t) ctrl_t <= 1'b1;
                    state <= SHIFT;
                    rsshr <= 1'b1;
                end
                SHIFT: begin
                    if (count == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                        state <= ADD;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Abort overrides the transition chosen above. The current
            // cycle's strobes are already out, so only the next ones are
            // cleared.
            if (abort_hit) begin
                state   <= IDLE;
                mrld    <= 1'b0;
                mdld    <= 1'b0;
                rsclear <= 1'b0;
                rsshr   <= 1'b0;
                done    <= 1'b0;
                busy    <= 1'b0;
            end
            if (abort_taint) ctrl_t <= 1'b1;
        end
    end

    always_comb begin
        rsload   = (state == ADD) & multiplierReg[count];
        rsload_t = ctrl_t | ((state == ADD) & multiplierReg_t);
    end

    assign mrld_t    = ctrl_t;
    assign mdld_t    = ctrl_t;
    assign rsclear_t = ctrl_t;
    assign rsshr_t   = ctrl_t;
    assign done_t    = ctrl_t;

endmodule

// File: tb/tb_multiplier_controller_taint_track_1bit.sv
// -----------------------------------------------------------------------------
// tb_multiplier_controller_taint_track_1bit
//
// Directed bench for multiplier_controller_taint_track_1bit with WIDTH=4.
// Outputs are sampled on the falling clock edge. Inputs change only on the
// falling edge.
// Strobe vector order: {mrld, mdld, rsclear, rsload, rsshr, busy, done}.
// Taint vector order:  {mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t, done_t}.
// -----------------------------------------------------------------------------
module tb_multiplier_controller_taint_track_1bit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       start_t;
    logic [3:0] multiplierReg;
    logic       multiplierReg_t;
`ifdef MULT_CTRL_ABORT_EN
    logic       abort;
    logic       abort_t;
`endif
    logic mrld, mrld_t, mdld, mdld_t, rsclear, rsclear_t;
    logic rsload, rsload_t, rsshr, rsshr_t, busy, done, done_t;

    int errors = 0;
    int checks = 0;

    logic [6:0] obs_s;
    logic [5:0] obs_t;
    assign obs_s = {mrld, mdld, rsclear, rsload, rsshr, busy, done};
    assign obs_t = {mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t, done_t};

    localparam logic [6:0] S_IDLE  = 7'b0000000;
    localparam logic [6:0] S_LOAD  = 7'b1110010;
    localparam logic [6:0] S_ADD0  = 7'b0000010;
    localparam logic [6:0] S_ADD1  = 7'b0001010;
    localparam logic [6:0] S_SHIFT = 7'b0000110;
    localparam logic [6:0] S_DONE  = 7'b0000011;

    always #5 clk = ~clk;

    multiplier_controller_taint_track_1bit #(.WIDTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .start_t         (start_t),
        .multiplierReg   (multiplierReg),
        .multiplierReg_t (multiplierReg_t),
`ifdef MULT_CTRL_ABORT_EN
        .abort           (abort),
        .abort_t         (abort_t),
`endif
        .mrld            (mrld),
        .mrld_t          (mrld_t),
        .mdld            (mdld),
        .mdld_t          (mdld_t),
        .rsclear         (rsclear),
        .rsclear_t       (rsclear_t),
        .rsload          (rsload),
        .rsload_t        (rsload_t),
        .rsshr           (rsshr),
        .rsshr_t         (rsshr_t),
        .busy            (busy),
        .done            (done),
        .done_t          (done_t)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [6:0] es, input logic [5:0] et);
        checks++;
        assert (obs_s === es) else begin
            errors++;
            $error("FAIL %s strobes: observed %b expected %b", tag, obs_s, es);
        end
        checks++;
        assert (obs_t === et) else begin
            errors++;
            $error("FAIL %s taints: observed %b expected %b", tag, obs_t, et);
        end
    endtask

    // Run one full operation from IDLE and check every cycle of it.
    // pt is the taint state at start; mt is the multiplierReg taint.
    task automatic do_op(input string tag, input logic [3:0] mr, input logic mt,
                         input logic pt);
        logic       ct;
        logic       rl_t;
        logic [6:0] es;
        multiplierReg   = mr;
        multiplierReg_t = mt;
        start = 1'b1;
        tick();
        start = 1'b0;
        ct = pt;
        for (int k = 1; k <= 10; k++) begin
            rl_t = ct;
            if (k == 1) es = S_LOAD;
            else if (k == 10) es = S_DONE;
            else if (k % 2 == 0) begin
                es   = mr[(k - 2) / 2] ? S_ADD1 : S_ADD0;
                rl_t = ct | mt;
            end else es = S_SHIFT;
            chk($sformatf("%s_c%0d", tag, k), es, {ct, ct, ct, rl_t, ct, ct});
            if ((k % 2 == 0) && (k != 10) && mt) ct = 1'b1;
            tick();
        end
        chk({tag, "_idle"}, S_IDLE, {6{ct}});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_t = 1'b0;
        multiplierReg = 4'b0000; multiplierReg_t = 1'b0;
`ifdef MULT_CTRL_ABORT_EN
        abort = 1'b0; abort_t = 1'b0;
`endif
        @(negedge clk);
        tick();
        chk("reset", S_IDLE, 6'b000000);
        reset = 1'b0;

        // Idle with no request for five cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle%0d", i), S_IDLE, 6'b000000);
        end

        // Main sequence: rsload pattern 1,1,0,1 over the ADD cycles.
        do_op("op1011", 4'b1011, 1'b0, 1'b0);
        // Zero multiplier: no rsload, still four shifts.
        do_op("op0000", 4'b0000, 1'b0, 1'b0);
        // Another pattern: rsload 0,1,1,0.
        do_op("op0110", 4'b0110, 1'b0, 1'b0);
        // Tainted multiplier: rsload_t in the first ADD, then all taints high.
        do_op("op1011t", 4'b1011, 1'b1, 1'b0);

        reset = 1'b1;
        tick();
        chk("reset2", S_IDLE, 6'b000000);
        reset = 1'b0;
        multiplierReg_t = 1'b0;

        // A tainted idle decision taints everything from the next cycle.
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        chk("start_t", S_IDLE, 6'b111111);
        do_op("op_after_t", 4'b1101, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        chk("reset3", S_IDLE, 6'b000000);
        reset = 1'b0;

        // Reset during the third SHIFT abandons the operation.
        multiplierReg = 4'b1011;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 7; k++) tick();
        chk("shift3", S_SHIFT, 6'b000000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_reset", S_IDLE, 6'b000000);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("no_done%0d", i), S_IDLE, 6'b000000);
        end
        do_op("op_after_rst", 4'b1011, 1'b0, 1'b0);

        // start held high: DONE, one IDLE cycle, then a new LOAD.
        multiplierReg = 4'b0000;
        start = 1'b1;
        tick();
        chk("hold_load", S_LOAD, 6'b000000);
        for (int k = 2; k <= 10; k++) tick();
        chk("hold_done", S_DONE, 6'b000000);
        tick();
        chk("hold_idle", S_IDLE, 6'b000000);
        tick();
        chk("hold_reload", S_LOAD, 6'b000000);
        start = 1'b0;
        for (int k = 2; k <= 10; k++) tick();
        chk("hold_done2", S_DONE, 6'b000000);
        tick();
        chk("hold_idle2", S_IDLE, 6'b000000);

`ifdef MULT_CTRL_ABORT_EN
        // Abort in ADD: strobes still driven that cycle, IDLE next, no done.
        multiplierReg = 4'b1011;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        chk("abort_add", S_ADD1, 6'b000000);
        tick();
        abort = 1'b0;
        chk("abort_idle", S_IDLE, 6'b000000);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("abort_nodone%0d", i), S_IDLE, 6'b000000);
        end
        // Tainted abort input in a working state taints everything.
        start = 1'b1;
        tick();
        start = 1'b0;
        abort_t = 1'b1;
        chk("abort_t_load", S_LOAD, 6'b000000);
        tick();
        abort_t = 1'b0;
        chk("abort_t_add", S_ADD1, 6'b111111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset4", S_IDLE, 6'b000000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
